// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg: shared definitions for the HI/LO issue/commit controller.
// Holds the R-type funct codes of the multiply/divide group, the data and
// funct widths, the controller state encoding and a small decode helper.
package hilo_ctrl_pkg;

  localparam int FUNCT_WIDTH = 6;
  localparam int DATA_WIDTH  = 32;

  // R-type funct codes handled by the controller
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIVU  = 6'h1B;

  // The "no request" value on the unit's funct bus
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_NONE  = 6'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } hilo_state_e;

  // True for MULT, MULTU, DIV and DIVU (contiguous code range)
  function automatic logic is_md(input logic [FUNCT_WIDTH-1:0] funct);
    return (funct >= FUNCT_MULT) && (funct <= FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: EX-side issue/commit controller for the multiply/divide unit.
// Decodes mult/div and HI/LO move instructions in EX, issues a held request
// to the multiply/divide unit, stalls EX until the unit reports done, and
// commits the 64-bit result into the architectural HI/LO registers.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 cancel EX instruction and any in-flight op
//   ex_valid_i, ex_funct_i  EX holds a valid R-type instr and its funct
//   ex_operand_1_i/_2_i     rs / rt values of the EX instruction
//   ex_accept_i             EX instruction advances to MEM this cycle
//   stall_req_o             hold EX (combinational)
//   hi_o, lo_o              architectural HI/LO (registered)
//   md_funct_o              request funct to the unit, 0 when idle
//   md_operand_1_o/_2_o     latched operands for the unit
//   md_flush_o              one-cycle abort pulse to the unit
//   md_done_i, md_result_i  unit completion and {HI, LO} result
module hilo_ctrl
  import hilo_ctrl_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    ex_valid_i,
  input  logic [FUNCT_WIDTH-1:0]  ex_funct_i,
  input  logic [DATA_WIDTH-1:0]   ex_operand_1_i,
  input  logic [DATA_WIDTH-1:0]   ex_operand_2_i,
  input  logic                    ex_accept_i,
  output logic                    stall_req_o,
  output logic [DATA_WIDTH-1:0]   hi_o,
  output logic [DATA_WIDTH-1:0]   lo_o,
  output logic [FUNCT_WIDTH-1:0]  md_funct_o,
  output logic [DATA_WIDTH-1:0]   md_operand_1_o,
  output logic [DATA_WIDTH-1:0]   md_operand_2_o,
  output logic                    md_flush_o,
  input  logic                    md_done_i,
  input  logic [2*DATA_WIDTH-1:0] md_result_i
);

  hilo_state_e             state_q, state_d;
  logic                    first_q, first_d;
  logic [FUNCT_WIDTH-1:0]  md_funct_q, md_funct_d;
  logic [DATA_WIDTH-1:0]   md_op1_q, md_op1_d;
  logic [DATA_WIDTH-1:0]   md_op2_q, md_op2_d;
  logic                    md_flush_q, md_flush_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;

  logic ex_md_s;
  logic issue_s;
  logic commit_s;
  logic mt_ok_s;

  assign ex_md_s  = ex_valid_i & is_md(ex_funct_i) & ~flush_i;
  assign issue_s  = (state_q == ST_IDLE) & ex_md_s;
  // A done seen in the first BUSY cycle belongs to the previous request
  // (the unit's done output may still be high), so it is ignored.
  assign commit_s = (state_q == ST_BUSY) & md_done_i & ~first_q;
  // MTHI/MTLO never reach EX while BUSY because EX is stalled then
  assign mt_ok_s  = ex_valid_i & ex_accept_i & ~flush_i & (state_q != ST_BUSY);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (commit_s) begin
          // DONE keeps the still-held instruction from issuing again
          state_d = ex_accept_i ? ST_IDLE : ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (flush_i || ex_accept_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM output: stall EX while its mult/div has not committed yet
  always_comb begin
    stall_req_o = 1'b0;
    if (ex_md_s && !commit_s && (state_q != ST_DONE)) begin
      stall_req_o = 1'b1;
    end else begin
      stall_req_o = 1'b0;
    end
  end

  // Next values of the request bus, abort pulse and HI/LO
  always_comb begin
    md_funct_d = md_funct_q;
    md_op1_d   = md_op1_q;
    md_op2_d   = md_op2_q;
    md_flush_d = 1'b0;
    first_d    = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    if (issue_s) begin
      md_funct_d = ex_funct_i;
      md_op1_d   = ex_operand_1_i;
      md_op2_d   = ex_operand_2_i;
      first_d    = 1'b1;
    end else if (state_q == ST_BUSY) begin
      // Dropping funct to 0 after commit or abort guarantees an idle
      // cycle on the request bus before any following request.
      if (flush_i || commit_s) begin
        md_funct_d = FUNCT_NONE;
      end else begin
        md_funct_d = md_funct_q;
      end
    end else begin
      md_funct_d = FUNCT_NONE;
    end

    if ((state_q == ST_BUSY) && flush_i) begin
      md_flush_d = 1'b1;
    end else begin
      md_flush_d = 1'b0;
    end

    if (commit_s && !flush_i) begin
      hi_d = md_result_i[2*DATA_WIDTH-1:DATA_WIDTH];
      lo_d = md_result_i[DATA_WIDTH-1:0];
    end else if (mt_ok_s && (ex_funct_i == FUNCT_MTHI)) begin
      hi_d = ex_operand_1_i;
    end else if (mt_ok_s && (ex_funct_i == FUNCT_MTLO)) begin
      lo_d = ex_operand_1_i;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // Request bus, abort pulse and HI/LO registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_q    <= 1'b0;
      md_funct_q <= FUNCT_NONE;
      md_op1_q   <= {DATA_WIDTH{1'b0}};
      md_op2_q   <= {DATA_WIDTH{1'b0}};
      md_flush_q <= 1'b0;
      hi_q       <= {DATA_WIDTH{1'b0}};
      lo_q       <= {DATA_WIDTH{1'b0}};
    end else begin
      first_q    <= first_d;
      md_funct_q <= md_funct_d;
      md_op1_q   <= md_op1_d;
      md_op2_q   <= md_op2_d;
      md_flush_q <= md_flush_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  assign md_funct_o     = md_funct_q;
  assign md_operand_1_o = md_op1_q;
  assign md_operand_2_o = md_op2_q;
  assign md_flush_o     = md_flush_q;

endmodule
